// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// counter-width rule used to size the bit counter.
package serial_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_e;

    // The counter must be able to represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
// The sub select is present only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif

endinterface

// File: rtl/fulladder.sv
// Team 1-bit full-adder cell.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per cycle through a single full-adder cell.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b and carry-in 1).
module serial_adder
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_r;
    state_e           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] b_load_s;
    logic             carry_load_s;
    logic             fa_sum_s;
    logic             fa_co_s;

    fulladder u_fa (
        .a  (a_r[0]),
        .b  (b_r[0]),
        .ci (carry_r),
        .s  (fa_sum_s),
        .co (fa_co_s)
    );

    // Operand B and initial carry as loaded on an accepted start.
    always_comb begin
        b_load_s     = bus.b;
        carry_load_s = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (bus.sub) begin
            b_load_s     = ~bus.b;
            carry_load_s = 1'b1;
        end else begin
            b_load_s     = bus.b;
            carry_load_s = bus.cin;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == LAST_BIT) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: operand capture, per-bit shift/add and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            // done trails the DONE state by one edge so it qualifies a settled result
            done_r <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= b_load_s;
                        carry_r <= carry_load_s;
                        cnt_r   <= '0;
                        sum_r   <= '0;
                        cout_r  <= 1'b0;
                        ovf_r   <= 1'b0;
                    end
                end
                SHIFT: begin
                    sum_r   <= {fa_sum_s, sum_r[WIDTH-1:1]};
                    a_r     <= {1'b0, a_r[WIDTH-1:1]};
                    b_r     <= {1'b0, b_r[WIDTH-1:1]};
                    carry_r <= fa_co_s;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    // On the MSB, carry_r is the carry into it and fa_co_s the carry out.
                    if (cnt_r == LAST_BIT) begin
                        cout_r <= fa_co_s;
                        ovf_r  <= carry_r ^ fa_co_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule
